// File: rtl/sr_latch_bank_ctrl_pkg.sv
// sr_latch_pkg: shared types and helpers for the SR latch bank controller.
//   state_t   : controller sequencing states (IDLE -> PULSE -> HOLD -> CHECK).
//   cnt_width : width of the phase cycle counter, clog2(max(pulse, hold) + 1).
package sr_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  function automatic int cnt_width(input int pulse_cycles, input int hold_cycles);
    int m;
    m = (pulse_cycles > hold_cycles) ? pulse_cycles : hold_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_latch_bank_ctrl_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin arbiter.
//   i_req   [NUM_REQ] : request vector
//   i_ptr   [IDW]     : last granted index; search starts at i_ptr+1 and wraps
//   o_grant [NUM_REQ] : one-hot grant (all zero when nothing requests)
//   o_idx   [IDW]     : encoded index of the granted requester
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx
);

  always_comb begin
    int unsigned c;
    logic        found;
    c       = 0;
    found   = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      c = (32'(i_ptr) + k) % NUM_REQ;
      if (!found && i_req[c]) begin
        found      = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl: round-robin write sequencer for a bank of NAND SR latches.
//   clk, rst_n              : clock, async active-low reset
//   req_valid/addr/val      : per-requester write requests (addr slice i*AW +: AW)
//   req_ready               : one-hot accept, only while IDLE
//   latch_s_n / latch_r_n   : registered active-low set/reset pulses to the bank
//   latch_q                 : bank readback
//   busy, grant_id          : not-IDLE flag, last accepted requester
//   err_mismatch, err_range : sticky error flags, cleared by err_clr (set wins)
module sr_latch_bank_ctrl
  import sr_latch_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_BITS     = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  localparam int AW  = $clog2(NUM_BITS),
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_val,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_BITS-1:0]   latch_s_n,
  output logic [NUM_BITS-1:0]   latch_r_n,
  input  logic [NUM_BITS-1:0]   latch_q,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  err_mismatch,
  output logic                  err_range,
  input  logic                  err_clr
);

  localparam int              CW         = cnt_width(PULSE_CYCLES, HOLD_CYCLES);
  localparam logic [CW-1:0]   PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [AW:0]     BANK_SIZE  = (AW+1)'(NUM_BITS);

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [AW-1:0]         r_addr, w_addr_nxt;
  logic                  r_val, w_val_nxt;
  logic [IDW-1:0]        r_ptr, w_ptr_nxt;
  logic [NUM_BITS-1:0]   r_s_n, r_r_n, w_s_n_nxt, w_r_n_nxt;
  logic                  r_err_m, r_err_r, w_err_m_nxt, w_err_r_nxt;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_gidx;
  logic                  w_idle, w_xfer, w_req_val, w_readback;
  logic [AW-1:0]         w_req_addr;
  logic [NUM_BITS-1:0]   w_req_dec, w_cur_dec;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = w_idle ? w_grant : '0;
  assign w_xfer    = |(req_valid & req_ready);

  always_comb begin
    w_req_addr = '0;
    w_req_val  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_req_addr = req_addr[k*AW +: AW];
        w_req_val  = req_val[k];
      end
    end
  end

  // Decoders avoid variable bit-selects that could run past NUM_BITS.
  always_comb begin
    w_req_dec = '0;
    w_cur_dec = '0;
    for (int unsigned i = 0; i < NUM_BITS; i++) begin
      w_req_dec[i] = (w_req_addr == AW'(i));
      w_cur_dec[i] = (r_addr == AW'(i));
    end
  end

  assign w_readback = |(latch_q & w_cur_dec);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_val_nxt   = r_val;
    w_ptr_nxt   = r_ptr;
    w_s_n_nxt   = '1;
    w_r_n_nxt   = '1;
    w_err_m_nxt = r_err_m & ~err_clr;
    w_err_r_nxt = r_err_r & ~err_clr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_ptr_nxt = w_gidx;
          if ({1'b0, w_req_addr} < BANK_SIZE) begin
            w_addr_nxt  = w_req_addr;
            w_val_nxt   = w_req_val;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_PULSE;
            // Pulse is registered at the accept edge so it starts at E0.
            if (w_req_val) w_s_n_nxt = ~w_req_dec;
            else           w_r_n_nxt = ~w_req_dec;
          end else begin
            w_err_r_nxt = 1'b1;
          end
        end
      end
      ST_PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_s_n_nxt = r_s_n;
          w_r_n_nxt = r_r_n;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_CHECK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_readback != r_val) w_err_m_nxt = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_val   <= 1'b0;
      r_ptr   <= IDW'(NUM_REQ - 1);
      r_s_n   <= '1;
      r_r_n   <= '1;
      r_err_m <= 1'b0;
      r_err_r <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_val   <= w_val_nxt;
      r_ptr   <= w_ptr_nxt;
      r_s_n   <= w_s_n_nxt;
      r_r_n   <= w_r_n_nxt;
      r_err_m <= w_err_m_nxt;
      r_err_r <= w_err_r_nxt;
    end
  end

  assign latch_s_n    = r_s_n;
  assign latch_r_n    = r_r_n;
  assign busy         = !w_idle;
  assign grant_id     = r_ptr;
  assign err_mismatch = r_err_m;
  assign err_range    = r_err_r;

  a_no_forbidden: assert property (@(posedge clk) disable iff (!rst_n)
    ((~latch_s_n & ~latch_r_n) == '0));
  a_single_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(~latch_s_n | ~latch_r_n));

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
module tb_sr_latch_bank_ctrl;
  localparam int NR  = 4;
  localparam int NB  = 6;
  localparam int P   = 2;
  localparam int H   = 1;
  localparam int AW  = $clog2(NB);
  localparam int IDW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR-1:0]     req_val = '0;
  logic [NR-1:0]     req_ready;
  logic [NB-1:0]     latch_s_n, latch_r_n, latch_q;
  logic              busy, err_mismatch, err_range;
  logic              err_clr = 1'b0;
  logic [IDW-1:0]    grant_id;

  always #5 clk = ~clk;

  sr_latch_bank_ctrl #(
    .NUM_REQ(NR), .NUM_BITS(NB), .PULSE_CYCLES(P), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_val(req_val), .req_ready(req_ready), .latch_s_n(latch_s_n),
    .latch_r_n(latch_r_n), .latch_q(latch_q), .busy(busy), .grant_id(grant_id),
    .err_mismatch(err_mismatch), .err_range(err_range), .err_clr(err_clr)
  );

  // Latch bank environment: NAND SR behaviour with optional stuck-at-0 bits.
  logic [NB-1:0] lq = '0;
  logic [NB-1:0] stuck = '0;
  always @(latch_s_n or latch_r_n or stuck) begin
    for (int i = 0; i < NB; i++) begin
      if (stuck[i])          lq[i] = 1'b0;
      else if (!latch_s_n[i]) lq[i] = 1'b1;
      else if (!latch_r_n[i]) lq[i] = 1'b0;
    end
  end
  assign latch_q = lq;

  typedef struct {
    logic [NB-1:0] s_n, r_n;
    bit busy, chk, val;
    int addr;
  } slot_t;

  typedef struct {
    logic [NB-1:0] s_n, r_n;
    logic busy;
    logic [IDW-1:0] gid;
    logic em, er;
    logic [NR-1:0] rdy;
  } exp_t;

  slot_t tl[$];
  exp_t  sb[$];
  int unsigned n_vec = 0, n_bad = 0;
  bit running = 1'b1;

  // Reference model: each accepted write becomes a timeline of P pulse cycles,
  // H quiet cycles and one readback cycle; the controller is idle when the
  // timeline is empty.
  int m_gid = NR - 1;
  bit m_em = 0, m_er = 0;

  initial forever begin
    @(negedge clk);
    if (running) begin
      exp_t  e;
      slot_t cur, s;
      int    win;
      bit    idle, set_m, set_r, rd;
      if (!rst_n) begin
        tl.delete();
        m_gid = NR - 1; m_em = 0; m_er = 0;
        e.s_n = '1; e.r_n = '1; e.busy = 0; e.gid = IDW'(NR - 1);
        e.em = 0; e.er = 0; e.rdy = '0;
        sb.push_back(e);
      end else begin
        idle = (tl.size() == 0);
        if (idle) begin
          cur.s_n = '1; cur.r_n = '1; cur.busy = 0; cur.chk = 0; cur.val = 0; cur.addr = 0;
        end else cur = tl[0];
        win = -1;
        if (idle)
          for (int k = 1; k <= NR; k++)
            if (win < 0 && req_valid[(m_gid + k) % NR]) win = (m_gid + k) % NR;
        e.s_n = cur.s_n; e.r_n = cur.r_n; e.busy = cur.busy;
        e.gid = IDW'(m_gid); e.em = m_em; e.er = m_er;
        e.rdy = (win >= 0) ? NR'(1 << win) : '0;
        sb.push_back(e);
        rd    = stuck[cur.addr] ? 1'b0 : cur.val;
        set_m = cur.chk && (rd != cur.val);
        set_r = 0;
        if (!idle) void'(tl.pop_front());
        if (win >= 0) begin
          int a;
          bit v;
          a = int'(req_addr[win*AW +: AW]);
          v = req_val[win];
          m_gid = win;
          if (a >= NB) set_r = 1;
          else begin
            s.addr = a; s.val = v; s.busy = 1; s.chk = 0;
            s.s_n = v ? ~NB'(1 << a) : '1;
            s.r_n = v ? '1 : ~NB'(1 << a);
            repeat (P) tl.push_back(s);
            s.s_n = '1; s.r_n = '1;
            repeat (H) tl.push_back(s);
            s.chk = 1;
            tl.push_back(s);
          end
        end
        m_em = set_m | (m_em & !err_clr);
        m_er = set_r | (m_er & !err_clr);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial forever begin
    @(negedge clk);
    #2;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      chk("latch_s_n", 32'(latch_s_n), 32'(e.s_n));
      chk("latch_r_n", 32'(latch_r_n), 32'(e.r_n));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("grant_id", 32'(grant_id), 32'(e.gid));
      chk("err_mismatch", 32'(err_mismatch), 32'(e.em));
      chk("err_range", 32'(err_range), 32'(e.er));
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_one(input int id, input int a, input bit v);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_addr[id*AW +: AW] = AW'(a);
    req_val[id] = v;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Contention from reset: expected grant order 0,1,2,3,0.
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW] = AW'(i);
      req_val[i] = i[0];
    end
    step(25);
    req_valid = '0;
    step(6);

    // Single write: req0 sets bit 3.
    set_one(0, 3, 1'b1);
    step(1);
    req_valid = '0;
    step(6);

    // Fairness: make req2 the last winner, then contend req2/req3.
    set_one(2, 1, 1'b0);
    step(1);
    req_valid = '0;
    step(6);
    req_valid = 4'b1100;
    req_addr[3*AW +: AW] = AW'(5); req_val[3] = 1'b1;
    step(10);
    req_valid = '0;
    step(6);

    // Out-of-range back to back, then a stuck-at-0 mismatch.
    set_one(1, 7, 1'b1);
    step(1);
    set_one(1, 6, 1'b0);
    step(1);
    req_valid = '0;
    step(2);
    stuck[4] = 1'b1;
    set_one(0, 4, 1'b1);
    step(1);
    req_valid = '0;
    step(6);
    stuck[4] = 1'b0;

    // Clear coinciding with a new range error: range flag stays set.
    set_one(3, 7, 1'b0);
    err_clr = 1'b1;
    step(1);
    req_valid = '0;
    err_clr = 1'b0;
    step(1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);

    // Reset during the first pulse cycle.
    set_one(1, 2, 1'b0);
    step(1);
    req_valid = '0;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);

    // Randomized traffic with bit 5 stuck at 0.
    stuck = NB'(1 << 5);
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = ($urandom_range(2, 0) == 0);
        req_addr[i*AW +: AW] = AW'($urandom_range(7, 0));
        req_val[i] = 1'($urandom_range(1, 0));
      end
      err_clr = ($urandom_range(15, 0) == 0);
      step(1);
    end
    req_valid = '0;
    err_clr = 1'b0;
    step(8);
    running = 1'b0;
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
